qreplicate: RTL and testbench



---
 rtl/qreplicate.sv | 157 +++++++++++++++
 tb/tb_qreplicate.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/qreplicate.sv
// qreplicate: streaming replicator for queue-typed data.
//
// Each accepted input {eot, val, len} is expanded into len output
// transactions that carry val. One new innermost eot level is added.
// It is set only on the last replica. The input's outer eot bits ride
// along on that last replica and are zero on every earlier one.
//
// Parameters
//   W_VAL     width of the replicated value
//   W_LEN     width of the unsigned replication count
//   LVL       number of eot bits on the input (0 = plain stream)
//   ZERO_MODE len==0 policy: 0 = wrap (2^W_LEN replicas),
//             1 = drop (consume, emit nothing), 2 = single replica
//   OUT_REG   0 = combinational output, 1 = 2-entry skid buffer on dout
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous, active-high reset
//   din_valid  input transaction valid
//   din_ready  input transaction accepted (only on the last replica)
//   din_data   {eot[LVL-1:0], val, len}
//   dout_valid output replica valid
//   dout_ready downstream ready
//   dout_data  {eot[LVL:0], val}

module qreplicate #(
    parameter int W_VAL     = 16,
    parameter int W_LEN     = 8,
    parameter int LVL       = 0,
    parameter int ZERO_MODE = 0,
    parameter int OUT_REG   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic [W_LEN+W_VAL+LVL-1:0] din_data,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [W_VAL+LVL:0]       dout_data
);

    localparam int W_OUT = W_VAL + LVL + 1;

    logic [W_LEN-1:0] len;
    logic [W_LEN-1:0] len_eff;
    logic [W_LEN-1:0] cnt_reg;
    logic [W_LEN-1:0] cnt_inc;
    logic [W_VAL-1:0] val;
    logic [LVL:0]     eot_out;
    logic             is_zero;
    logic             drop;
    logic             last;
    logic             core_valid;
    logic             core_ready;
    logic [W_OUT-1:0] core_data;

    assign len     = din_data[W_LEN-1:0];
    assign val     = din_data[W_LEN +: W_VAL];
    assign is_zero = (len == '0);

    // A zero-length input in drop mode is swallowed without ever
    // reaching the replication core.
    assign drop = (ZERO_MODE == 1) && is_zero;

    // In wrap mode len_eff stays 0, so last fires when the count wraps,
    // after 2^W_LEN replicas.
    always_comb begin
        len_eff = len;
        if (is_zero && (ZERO_MODE == 2))
            len_eff = W_LEN'(1);
    end

    assign cnt_inc = cnt_reg + W_LEN'(1);
    assign last    = (cnt_inc == len_eff);

    assign eot_out[0] = last;

    generate
        if (LVL > 0) begin : g_outer
            logic [LVL-1:0] eot_in;
            assign eot_in         = din_data[W_LEN+W_VAL +: LVL];
            // Outer levels only close on the final replica.
            assign eot_out[LVL:1] = eot_in & {LVL{last}};
        end
    endgenerate

    assign core_valid = din_valid & ~drop;
    assign core_data  = {eot_out, val};

    // The input is held by the source until its last replica leaves.
    // ready is suppressed during reset so a partially replicated input
    // is never consumed; the source re-presents it afterwards.
    assign din_ready = ~rst & din_valid & (drop | (core_ready & last));

    always_ff @(posedge clk) begin
        if (rst)
            cnt_reg <= '0;
        else if (core_valid && core_ready)
            cnt_reg <= last ? '0 : cnt_inc;
    end

    generate
        if (OUT_REG != 0) begin : g_skid
            // Two-entry buffer: head drives dout, tail catches the one
            // replica that can arrive while the head is stalled.
            // core_ready is the registered "tail empty" flag, so
            // dout_ready never reaches din_ready combinationally.
            logic             v0, v1;
            logic [W_OUT-1:0] d0, d1;
            logic             push, pop;

            assign core_ready = ~v1;
            assign push       = core_valid & core_ready;
            assign pop        = v0 & dout_ready;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v0 <= 1'b0;
                    v1 <= 1'b0;
                end else begin
                    case ({push, pop})
                        2'b10: begin
                            if (!v0) begin
                                v0 <= 1'b1;
                                d0 <= core_data;
                            end else begin
                                v1 <= 1'b1;
                                d1 <= core_data;
                            end
                        end
                        2'b01: begin
                            if (v1) begin
                                d0 <= d1;
                                v1 <= 1'b0;
                            end else begin
                                v0 <= 1'b0;
                            end
                        end
                        // push implies the tail is empty, so the new
                        // replica simply replaces the departing head.
                        2'b11:   d0 <= core_data;
                        default: ;
                    endcase
                end
            end

            assign dout_valid = v0;
            assign dout_data  = d0;
        end else begin : g_comb
            assign core_ready = dout_ready;
            assign dout_valid = core_valid;
            assign dout_data  = core_data;
        end
    endgenerate

endmodule

// File: tb/tb_qreplicate.sv
// Bench for qreplicate: several parameterisations side by side, driven
// from a table of per-cycle vectors plus hand-written sequences for the
// skid-buffered variant (random backpressure, throughput, reset).
module tb_qreplicate;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        vin [6];
    logic        rdy [6];
    logic        vout[6];
    logic        rin [6];
    logic [31:0] dq  [6];

    logic [11:0] d0;
    logic [12:0] d1;
    logic [10:0] dz0, dz1, dz2;
    logic [12:0] dr;
    logic [8:0]  q0;
    logic [9:0]  q1;
    logic [8:0]  qz0, qz1, qz2;
    logic [9:0]  qr;

    qreplicate #(.W_VAL(8), .W_LEN(4), .LVL(0), .ZERO_MODE(0), .OUT_REG(0)) u0 (
        .clk(clk), .rst(rst), .din_valid(vin[0]), .din_ready(rin[0]), .din_data(d0),
        .dout_valid(vout[0]), .dout_ready(rdy[0]), .dout_data(q0));
    qreplicate #(.W_VAL(8), .W_LEN(4), .LVL(1), .ZERO_MODE(0), .OUT_REG(0)) u1 (
        .clk(clk), .rst(rst), .din_valid(vin[1]), .din_ready(rin[1]), .din_data(d1),
        .dout_valid(vout[1]), .dout_ready(rdy[1]), .dout_data(q1));
    qreplicate #(.W_VAL(8), .W_LEN(3), .LVL(0), .ZERO_MODE(0), .OUT_REG(0)) uz0 (
        .clk(clk), .rst(rst), .din_valid(vin[2]), .din_ready(rin[2]), .din_data(dz0),
        .dout_valid(vout[2]), .dout_ready(rdy[2]), .dout_data(qz0));
    qreplicate #(.W_VAL(8), .W_LEN(3), .LVL(0), .ZERO_MODE(1), .OUT_REG(0)) uz1 (
        .clk(clk), .rst(rst), .din_valid(vin[3]), .din_ready(rin[3]), .din_data(dz1),
        .dout_valid(vout[3]), .dout_ready(rdy[3]), .dout_data(qz1));
    qreplicate #(.W_VAL(8), .W_LEN(3), .LVL(0), .ZERO_MODE(2), .OUT_REG(0)) uz2 (
        .clk(clk), .rst(rst), .din_valid(vin[4]), .din_ready(rin[4]), .din_data(dz2),
        .dout_valid(vout[4]), .dout_ready(rdy[4]), .dout_data(qz2));
    qreplicate #(.W_VAL(8), .W_LEN(4), .LVL(1), .ZERO_MODE(0), .OUT_REG(1)) ur (
        .clk(clk), .rst(rst), .din_valid(vin[5]), .din_ready(rin[5]), .din_data(dr),
        .dout_valid(vout[5]), .dout_ready(rdy[5]), .dout_data(qr));

    assign dq[0] = {23'd0, q0};
    assign dq[1] = {22'd0, q1};
    assign dq[2] = {23'd0, qz0};
    assign dq[3] = {23'd0, qz1};
    assign dq[4] = {23'd0, qz2};
    assign dq[5] = {22'd0, qr};

    typedef struct {
        int          sel;
        logic        vi;
        logic [31:0] din;
        logic        r;
        logic        ev;
        logic [31:0] ed;
        logic        er;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic void add(input int sel, input logic vi, input logic [31:0] din,
                                input logic r, input logic ev, input logic [31:0] ed,
                                input logic er);
        vec_t v;
        v.sel = sel; v.vi = vi; v.din = din; v.r = r; v.ev = ev; v.ed = ed; v.er = er;
        vecs.push_back(v);
    endfunction

    task automatic drive_data(input int sel, input logic [31:0] x);
        case (sel)
            0: d0  = x[11:0];
            1: d1  = x[12:0];
            2: dz0 = x[10:0];
            3: dz1 = x[10:0];
            4: dz2 = x[10:0];
            default: dr = x[12:0];
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   xfers, pulses;
        logic busy, stall_prev;
        logic [31:0] prev;

        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin vin[k] = 1'b0; rdy[k] = 1'b1; end
        d0 = '0; d1 = '0; dz0 = '0; dz1 = '0; dz2 = '0; dr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_dout_valid_reg", {31'd0, vout[5]}, 0);
        for (int k = 0; k < 6; k++) chk($sformatf("rst_din_ready%0d", k), {31'd0, rin[k]}, 0);
        @(negedge clk); rst = 1'b0; #1;
        chk("post_rst_dout_valid_reg", {31'd0, vout[5]}, 0);

        // LVL=0, W_LEN=4: val=A5 len=3
        add(0, 1, 32'hA53, 1, 1, 32'h0A5, 0);
        add(0, 1, 32'hA53, 1, 1, 32'h0A5, 0);
        add(0, 1, 32'hA53, 1, 1, 32'h1A5, 1);
        add(0, 0, 32'h000, 1, 0, 32'h000, 0);
        // backpressure: val=3C len=2, first cycle stalled
        add(0, 1, 32'h3C2, 0, 1, 32'h03C, 0);
        add(0, 1, 32'h3C2, 1, 1, 32'h03C, 0);
        add(0, 1, 32'h3C2, 1, 1, 32'h13C, 1);
        // max len 15: val=E1
        for (int i = 0; i < 14; i++) add(0, 1, 32'hE1F, 1, 1, 32'h0E1, 0);
        add(0, 1, 32'hE1F, 1, 1, 32'h1E1, 1);
        // LVL=1: {0,01,2} then {1,02,1}, then {1,07,2}
        add(1, 1, 32'h0012, 1, 1, 32'h001, 0);
        add(1, 1, 32'h0012, 1, 1, 32'h101, 1);
        add(1, 1, 32'h1021, 1, 1, 32'h302, 1);
        add(1, 1, 32'h1072, 1, 1, 32'h007, 0);
        add(1, 1, 32'h1072, 1, 1, 32'h307, 1);
        // len=0, W_LEN=3, val=55: wrap gives 8 replicas
        for (int i = 0; i < 7; i++) add(2, 1, 32'h2A8, 1, 1, 32'h055, 0);
        add(2, 1, 32'h2A8, 1, 1, 32'h155, 1);
        // drop: consumed, nothing emitted, count untouched
        add(3, 1, 32'h2A8, 1, 0, 32'h000, 1);
        add(3, 1, 32'h2AA, 1, 1, 32'h055, 0);
        add(3, 1, 32'h2AA, 1, 1, 32'h155, 1);
        // single
        add(4, 1, 32'h2A8, 1, 1, 32'h155, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            for (int k = 0; k < 6; k++) vin[k] = 1'b0;
            vin[vecs[i].sel] = vecs[i].vi;
            rdy[vecs[i].sel] = vecs[i].r;
            drive_data(vecs[i].sel, vecs[i].din);
            #1;
            chk($sformatf("vec%0d_dout_valid", i), {31'd0, vout[vecs[i].sel]}, {31'd0, vecs[i].ev});
            if (vecs[i].ev)
                chk($sformatf("vec%0d_dout_data", i), dq[vecs[i].sel], vecs[i].ed);
            chk($sformatf("vec%0d_din_ready", i), {31'd0, rin[vecs[i].sel]}, {31'd0, vecs[i].er});
        end
        @(negedge clk);
        for (int k = 0; k < 6; k++) vin[k] = 1'b0;

        // Skid variant, sustained throughput: {0,11,4}, one cycle latency
        dr = 13'h0114; rdy[5] = 1'b1; busy = 1'b1; pulses = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk); vin[5] = busy; #1;
            if (c == 0)
                chk("B_latency", {31'd0, vout[5]}, 0);
            else if (c <= 4) begin
                chk($sformatf("B_valid%0d", c), {31'd0, vout[5]}, 1);
                chk($sformatf("B_data%0d", c), dq[5], (c == 4) ? 32'h111 : 32'h011);
            end else
                chk($sformatf("B_idle%0d", c), {31'd0, vout[5]}, 0);
            if (rin[5]) begin
                pulses++;
                chk("B_din_ready_cycle", c, 3);
                busy = 1'b0;
            end
        end
        chk("B_din_ready_once", pulses, 1);

        // Skid variant, random backpressure: {1,9C,5}
        dr = 13'h19C5; busy = 1'b1; xfers = 0; pulses = 0; stall_prev = 1'b0; prev = '0;
        for (int c = 0, tail = 0; c < 300 && tail < 6; c++) begin
            @(negedge clk); vin[5] = busy; rdy[5] = 1'($urandom_range(0, 1)); #1;
            if (stall_prev) begin
                chk("A_hold_valid", {31'd0, vout[5]}, 1);
                chk("A_hold_data", dq[5], prev);
            end
            if (vout[5] && rdy[5]) begin
                xfers++;
                if (xfers <= 5)
                    chk($sformatf("A_data%0d", xfers), dq[5], (xfers == 5) ? 32'h39C : 32'h09C);
            end
            stall_prev = vout[5] & ~rdy[5];
            prev = dq[5];
            if (rin[5]) begin pulses++; busy = 1'b0; end
            if (xfers >= 5) tail++;
        end
        chk("A_count", xfers, 5);
        chk("A_din_ready_once", pulses, 1);

        // Skid variant, reset after 2 of 4 replicas: {1,77,4}
        dr = 13'h1774; rdy[5] = 1'b1; xfers = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); vin[5] = 1'b1; #1;
            chk($sformatf("C_pre_din_ready%0d", c), {31'd0, rin[5]}, 0);
            if (vout[5]) begin
                xfers++;
                chk($sformatf("C_pre_data%0d", xfers), dq[5], 32'h077);
            end
        end
        chk("C_pre_count", xfers, 2);
        @(negedge clk); rst = 1'b1; #1;
        chk("C_rst_din_ready", {31'd0, rin[5]}, 0);
        @(negedge clk); rst = 1'b0; #1;
        chk("C_post_rst_valid", {31'd0, vout[5]}, 0);
        chk("C_post_rst_din_ready", {31'd0, rin[5]}, 0);
        xfers = 0; pulses = 0; busy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); vin[5] = busy; #1;
            if (vout[5] && rdy[5]) begin
                xfers++;
                if (xfers <= 4)
                    chk($sformatf("C_data%0d", xfers), dq[5], (xfers == 4) ? 32'h377 : 32'h077);
            end
            if (rin[5]) begin pulses++; busy = 1'b0; end
        end
        chk("C_count", xfers, 4);
        chk("C_din_ready_once", pulses, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
